// File: rtl/cv32e41p_rf_write_arbiter.sv
// Register-file write arbiter: EX on port A, LSU or MULT/DIV on port B, with x0/collision rules
// and MULT/DIV anti-starvation. Define CV32E41P_RF_FWD_EN to forward in-flight writes onto read data.
module cv32e41p_rf_write_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_we_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  md_valid_i,
  output logic                  md_ready_o,
  input  logic [ADDR_WIDTH-1:0] md_waddr_i,
  input  logic [DATA_WIDTH-1:0] md_wdata_i,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_a_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_b_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_c_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  output logic [DATA_WIDTH-1:0] rdata_c_o,
  output logic                  collision_o
);

  typedef enum logic {PRIO_LSU, PRIO_MD} prio_e;

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

  prio_e      prio_q;
  logic [3:0] starve_cnt_q;
  logic       lsu_gnt, md_gnt, md_denied, b_gnt;

  always_comb begin
    lsu_gnt   = lsu_valid_i && (!md_valid_i || (prio_q == PRIO_LSU));
    md_gnt    = md_valid_i && !lsu_gnt;
    md_denied = md_valid_i && lsu_gnt;
    b_gnt     = lsu_gnt || md_gnt;

    we_a_o    = ex_we_i && (ex_waddr_i != '0);
    waddr_a_o = ex_waddr_i;
    wdata_a_o = ex_wdata_i;

    waddr_b_o = lsu_gnt ? lsu_waddr_i : md_waddr_i;
    wdata_b_o = lsu_gnt ? lsu_wdata_i : md_wdata_i;

    // EX is younger than any long-latency result, so on a shared target the port-B write is dead.
    collision_o = b_gnt && we_a_o && (waddr_b_o == ex_waddr_i);
    we_b_o      = b_gnt && (waddr_b_o != '0) && !collision_o;

    lsu_ready_o = lsu_gnt;
    md_ready_o  = md_gnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= PRIO_LSU;
      starve_cnt_q <= '0;
    end else if (md_gnt) begin
      prio_q       <= PRIO_LSU;
      starve_cnt_q <= '0;
    end else if (md_denied) begin
      if (starve_cnt_q == STARVE_LAST) prio_q <= PRIO_MD;
      if (starve_cnt_q != 4'hF) starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end

`ifdef CV32E41P_RF_FWD_EN
  logic                  fwd_a_vld_p1, fwd_b_vld_p1;
  logic [ADDR_WIDTH-1:0] fwd_a_addr_p1, fwd_b_addr_p1;
  logic [DATA_WIDTH-1:0] fwd_a_data_p1, fwd_b_data_p1;

  // Stage 1: writes issued last cycle, still in flight through the latch RF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_vld_p1 <= 1'b0;
      fwd_b_vld_p1 <= 1'b0;
    end else begin
      fwd_a_vld_p1 <= we_a_o;
      fwd_b_vld_p1 <= we_b_o;
    end
  end

  always_ff @(posedge clk) begin
    if (we_a_o) begin
      fwd_a_addr_p1 <= waddr_a_o;
      fwd_a_data_p1 <= wdata_a_o;
    end
    if (we_b_o) begin
      fwd_b_addr_p1 <= waddr_b_o;
      fwd_b_data_p1 <= wdata_b_o;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] fwd_mux(input logic [ADDR_WIDTH-1:0] ra,
                                                    input logic [DATA_WIDTH-1:0] rf);
    if (ra == '0)                                 return rf;
    if (we_a_o && (waddr_a_o == ra))              return wdata_a_o;
    if (we_b_o && (waddr_b_o == ra))              return wdata_b_o;
    if (fwd_a_vld_p1 && (fwd_a_addr_p1 == ra))    return fwd_a_data_p1;
    if (fwd_b_vld_p1 && (fwd_b_addr_p1 == ra))    return fwd_b_data_p1;
    return rf;
  endfunction

  always_comb begin
    rdata_a_o = fwd_mux(raddr_a_i, rf_rdata_a_i);
    rdata_b_o = fwd_mux(raddr_b_i, rf_rdata_b_i);
    rdata_c_o = fwd_mux(raddr_c_i, rf_rdata_c_i);
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr_a_i, raddr_b_i, raddr_c_i};

  assign rdata_a_o = rf_rdata_a_i;
  assign rdata_b_o = rf_rdata_b_i;
  assign rdata_c_o = rf_rdata_c_i;
`endif

endmodule

// File: tb/tb_cv32e41p_rf_write_arbiter.sv
// Bench for cv32e41p_rf_write_arbiter: directed steps plus constrained-random traffic against a reference model.
module tb_cv32e41p_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  logic          clk, rst_n;
  logic          ex_we, lsu_valid, md_valid;
  logic [AW-1:0] ex_waddr, lsu_waddr, md_waddr, raddr_a, raddr_b, raddr_c;
  logic [DW-1:0] ex_wdata, lsu_wdata, md_wdata, rf_rdata_a, rf_rdata_b, rf_rdata_c;
  logic          lsu_ready, md_ready, we_a, we_b, collision;
  logic [AW-1:0] waddr_a, waddr_b;
  logic [DW-1:0] wdata_a, wdata_b, rdata_a, rdata_b, rdata_c;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: consecutive MULT/DIV denials and the writes issued last cycle.
  int            md_denials;
  bit            hist_a_v, hist_b_v;
  logic [AW-1:0] hist_a_addr, hist_b_addr;
  logic [DW-1:0] hist_a_data, hist_b_data;
  bit            e_we_a, e_we_b, e_col, lsu_win, md_win;
  logic [AW-1:0] e_baddr;
  logic [DW-1:0] e_bdata;

  cv32e41p_rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .md_valid_i(md_valid), .md_ready_o(md_ready), .md_waddr_i(md_waddr), .md_wdata_i(md_wdata),
    .we_a_o(we_a), .waddr_a_o(waddr_a), .wdata_a_o(wdata_a),
    .we_b_o(we_b), .waddr_b_o(waddr_b), .wdata_b_o(wdata_b),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b), .rf_rdata_c_i(rf_rdata_c),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .rdata_c_o(rdata_c),
    .collision_o(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] ra, input logic [DW-1:0] rf);
`ifdef CV32E41P_RF_FWD_EN
    if (ra == 0)                               return rf;
    if (e_we_a && ex_waddr == ra)              return ex_wdata;
    if (e_we_b && e_baddr == ra)               return e_bdata;
    if (hist_a_v && hist_a_addr == ra)         return hist_a_data;
    if (hist_b_v && hist_b_addr == ra)         return hist_b_data;
`endif
    return rf;
  endfunction

  task automatic zero_inputs();
    ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    lsu_valid = 0; lsu_waddr = 0; lsu_wdata = 0;
    md_valid = 0; md_waddr = 0; md_wdata = 0;
    raddr_a = 0; raddr_b = 0; raddr_c = 0;
    rf_rdata_a = 0; rf_rdata_b = 0; rf_rdata_c = 0;
  endtask

  // Settle, compare every output with the model, then advance the model across the coming edge.
  task automatic check_cycle();
    #1;
    if (!rst_n) begin
      md_denials = 0;
      hist_a_v = 0;
      hist_b_v = 0;
    end
    e_we_a  = ex_we && (ex_waddr != 0);
    lsu_win = lsu_valid && (!md_valid || md_denials < LIMIT);
    md_win  = md_valid && !lsu_win;
    e_baddr = lsu_win ? lsu_waddr : md_waddr;
    e_bdata = lsu_win ? lsu_wdata : md_wdata;
    e_col   = (lsu_win || md_win) && e_we_a && (e_baddr == ex_waddr);
    e_we_b  = (lsu_win || md_win) && (e_baddr != 0) && !e_col;
    chk("we_a", we_a, e_we_a);
    chk("waddr_a", waddr_a, ex_waddr);
    chk("wdata_a", wdata_a, ex_wdata);
    chk("we_b", we_b, e_we_b);
    if (e_we_b) begin
      chk("waddr_b", waddr_b, e_baddr);
      chk("wdata_b", wdata_b, e_bdata);
    end
    chk("lsu_ready", lsu_ready, lsu_win);
    chk("md_ready", md_ready, md_win);
    chk("collision", collision, e_col);
    chk("rdata_a", rdata_a, exp_rdata(raddr_a, rf_rdata_a));
    chk("rdata_b", rdata_b, exp_rdata(raddr_b, rf_rdata_b));
    chk("rdata_c", rdata_c, exp_rdata(raddr_c, rf_rdata_c));
    if (rst_n) begin
      if (md_win) md_denials = 0;
      else if (md_valid) md_denials++;
      hist_a_v = e_we_a; hist_a_addr = ex_waddr; hist_a_data = ex_wdata;
      hist_b_v = e_we_b; hist_b_addr = e_baddr;  hist_b_data = e_bdata;
    end
  endtask

  initial begin
    logic [DW-1:0] fwd_exp [3];
    logic [AW-1:0] last_lsu_addr;

    // Reset with all inputs low: every output is zero.
    rst_n = 0;
    zero_inputs();
    check_cycle();
    chk("reset_rdata_a", rdata_a, 0);
    chk("reset_we_b", we_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    // EX-only write.
    @(negedge clk);
    zero_inputs();
    ex_we = 1; ex_waddr = 5; ex_wdata = 32'hA5A5A5A5;
    check_cycle();
    chk("ex_we_a", we_a, 1);
    chk("ex_waddr_a", waddr_a, 5);
    chk("ex_we_b", we_b, 0);
    chk("ex_lsu_ready", lsu_ready, 0);
    chk("ex_md_ready", md_ready, 0);

    // Persistent tie: LSU for four cycles, then MULT/DIV once, then LSU again.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      zero_inputs();
      lsu_valid = 1; lsu_waddr = 5'(10 + i); lsu_wdata = 32'(i);
      md_valid = 1; md_waddr = 5'd20; md_wdata = 32'h0000_3D3D + 32'(i);
      check_cycle();
      chk($sformatf("tie%0d_lsu_ready", i), lsu_ready, (i != 4));
      chk($sformatf("tie%0d_md_ready", i), md_ready, (i == 4));
    end

    // Same-address collision between EX and LSU.
    @(negedge clk);
    zero_inputs();
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'h1111;
    lsu_valid = 1; lsu_waddr = 7; lsu_wdata = 32'h2222;
    check_cycle();
    chk("col_we_a", we_a, 1);
    chk("col_we_b", we_b, 0);
    chk("col_lsu_ready", lsu_ready, 1);
    chk("col_flag", collision, 1);

    // MULT/DIV result to x0 completes but writes nothing.
    @(negedge clk);
    zero_inputs();
    md_valid = 1; md_waddr = 0; md_wdata = 32'hFFFF;
    check_cycle();
    chk("x0_md_ready", md_ready, 1);
    chk("x0_we_b", we_b, 0);
    chk("x0_collision", collision, 0);

    // LSU write of x9 then read-back through port B over three cycles.
`ifdef CV32E41P_RF_FWD_EN
    fwd_exp = '{32'h1234, 32'h1234, 32'hDEAD};
`else
    fwd_exp = '{32'hDEAD, 32'hDEAD, 32'hDEAD};
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      zero_inputs();
      if (i == 0) begin
        lsu_valid = 1; lsu_waddr = 9; lsu_wdata = 32'h1234;
      end
      raddr_b = 9; rf_rdata_b = 32'hDEAD;
      check_cycle();
      chk($sformatf("fwd_n%0d_rdata_b", i), rdata_b, fwd_exp[i]);
    end

    // Randomized traffic; a source that was not accepted keeps its result stable.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ex_we = 1'($urandom_range(0, 1));
      ex_waddr = 5'($urandom_range(0, 7));
      ex_wdata = $urandom;
      if (!(lsu_valid && !lsu_win)) begin
        lsu_valid = 1'($urandom_range(0, 2) != 0);
        lsu_waddr = 5'($urandom_range(0, 7));
        lsu_wdata = $urandom;
      end
      if (!(md_valid && !md_win)) begin
        md_valid = 1'($urandom_range(0, 2) != 0);
        md_waddr = 5'($urandom_range(0, 7));
        md_wdata = $urandom;
      end
      raddr_a = 5'($urandom_range(0, 7)); rf_rdata_a = $urandom;
      raddr_b = 5'($urandom_range(0, 7)); rf_rdata_b = $urandom;
      raddr_c = 5'($urandom_range(0, 7)); rf_rdata_c = $urandom;
      check_cycle();
    end

    // Drive into MULT/DIV priority, then reset mid-cycle.
    @(negedge clk);
    zero_inputs();
    md_valid = 1; md_waddr = 3; md_wdata = 32'h33;
    check_cycle();
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge clk);
      zero_inputs();
      lsu_valid = 1; lsu_waddr = 5'(12 + i); lsu_wdata = 32'hC0DE_0000 + 32'(i);
      md_valid = 1; md_waddr = 4; md_wdata = 32'h44;
      check_cycle();
      chk($sformatf("pre_rst_tie%0d_lsu_ready", i), lsu_ready, 1);
    end
    last_lsu_addr = 5'(12 + LIMIT - 1);
    @(negedge clk);
    #2;
    rst_n = 0;
    zero_inputs();
    raddr_a = last_lsu_addr;
    check_cycle();
    chk("rst_rdata_a_cleared", rdata_a, 0);
    chk("rst_md_ready", md_ready, 0);
    @(negedge clk);
    check_cycle();
    @(negedge clk);
    rst_n = 1;
    zero_inputs();
    lsu_valid = 1; lsu_waddr = 6; lsu_wdata = 32'h66;
    md_valid = 1; md_waddr = 8; md_wdata = 32'h88;
    check_cycle();
    chk("post_rst_tie_lsu", lsu_ready, 1);
    chk("post_rst_tie_md", md_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
